// File: rtl/stopwatch_pkg.sv
// Shared seven-segment constants and nibble decode for the stopwatch cores.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package stopwatch_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] code;
    code = SEG_0;
    case (nibble)
      4'h1: code = SEG_1;
      4'h2: code = SEG_2;
      4'h3: code = SEG_3;
      4'h4: code = SEG_4;
      4'h5: code = SEG_5;
      4'h6: code = SEG_6;
      4'h7: code = SEG_7;
      4'h8: code = SEG_8;
      4'h9: code = SEG_9;
      4'hA: code = SEG_A;
      4'hB: code = SEG_B;
      4'hC: code = SEG_C;
      4'hD: code = SEG_D;
      4'hE: code = SEG_E;
      4'hF: code = SEG_F;
      default: code = SEG_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Registered single-digit hex to active-low seven-segment decoder.
module hex_seg_decoder
  import stopwatch_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      seg <= SEG_0;
    end else begin
      seg <= hex_to_seg(nibble);
    end
  end

endmodule

// File: rtl/hex_stopwatch_multi.sv
// Multi-digit hex stopwatch: prescaled up/down count with saturate or wrap,
// sticky limit flag, lap-hold display latch and registered segment outputs.
module hex_stopwatch_multi
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000000,
  parameter int SATURATE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pause,
  input  logic                  clear,
  input  logic                  dir,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  tick,
  output logic                  limit,
  output logic                  held
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [PW-1:0] presc;
  logic [CW-1:0] latch;
  logic [CW-1:0] disp;
  logic          tick_evt;
  logic          at_limit;

  // Plain modular step; at the limit either hold there or wrap.
  function automatic logic [CW-1:0] step_count(input logic [CW-1:0] cur, input logic down);
    logic [CW-1:0] nxt;
    if (!down) begin
      nxt = (cur == '1) ? ((SATURATE != 0) ? cur : '0) : cur + CNT_ONE;
    end else begin
      nxt = (cur == '0) ? ((SATURATE != 0) ? cur : '1) : cur - CNT_ONE;
    end
    return nxt;
  endfunction

  assign tick_evt = !pause && (presc == PRESC_LAST);
  assign at_limit = dir ? (count == '0) : (count == '1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      presc <= '0;
      count <= '0;
      latch <= '0;
      tick  <= 1'b0;
      limit <= 1'b0;
      held  <= 1'b0;
    end else if (clear) begin
      presc <= '0;
      count <= '0;
      tick  <= 1'b0;
      limit <= 1'b0;
      held  <= 1'b0;
    end else if (pause) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= tick_evt;
      if (tick_evt) begin
        presc <= '0;
        count <= step_count(count, dir);
        if (at_limit) limit <= 1'b1;
      end else begin
        presc <= presc + PRESC_ONE;
      end
      // latch sees the pre-step count when lap lands on a tick
      if (lap) begin
        if (!held) latch <= count;
        held <= !held;
      end
    end
  end

  // Display register stage: one cycle behind count/held
  assign disp = held ? latch : count;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    hex_seg_decoder u_dec (
      .clock  (clock),
      .reset  (reset),
      .nibble (disp[4*k+3 -: 4]),
      .seg    (seg[7*k+6 -: 7])
    );
  end

endmodule

// File: tb/tb_hex_stopwatch_multi.sv
// Scoreboard bench: two instances (saturate and wrap) against a behavioural model.
module tb_hex_stopwatch_multi;

  localparam int TD   = 4;
  localparam int MAXV = 255;

  logic clock = 1'b0;
  logic reset = 1'b0, pause = 1'b0, clear = 1'b0, dir = 1'b0, lap = 1'b0;

  logic [7:0]  c0, c1;
  logic [13:0] s0, s1;
  logic        t0, t1, l0, l1, h0, h1;

  always #5 clock = ~clock;

  hex_stopwatch_multi #(.DIGITS(2), .TICK_DIV(TD), .SATURATE(1)) dut_sat (
    .clock(clock), .reset(reset), .pause(pause), .clear(clear), .dir(dir), .lap(lap),
    .count(c0), .seg(s0), .tick(t0), .limit(l0), .held(h0)
  );

  hex_stopwatch_multi #(.DIGITS(2), .TICK_DIV(TD), .SATURATE(0)) dut_wrap (
    .clock(clock), .reset(reset), .pause(pause), .clear(clear), .dir(dir), .lap(lap),
    .count(c1), .seg(s1), .tick(t1), .limit(l1), .held(h1)
  );

  typedef struct {
    logic [7:0]  cnt;
    logic [13:0] seg;
    logic        tick;
    logic        limit;
    logic        held;
    int          phase;
  } exp_t;

  exp_t q [2][$];

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: index 0 saturates, index 1 wraps.
  int m_cnt [2];
  int m_presc [2];
  int m_latch [2];
  bit m_held [2];
  bit m_limit [2];
  bit m_tick [2];

  function automatic logic [13:0] enc(input int v);
    logic [3:0] hi, lo;
    hi = v[7:4];
    lo = v[3:0];
    return {segtab[hi], segtab[lo]};
  endfunction

  task automatic model_step(input int s, input logic r, input logic c, input logic p,
                            input logic d, input logic l, input int ph);
    exp_t e;
    int old_cnt;
    int old_disp;
    old_cnt  = m_cnt[s];
    old_disp = m_held[s] ? m_latch[s] : m_cnt[s];
    if (!r) begin
      m_cnt[s] = 0; m_presc[s] = 0; m_latch[s] = 0;
      m_held[s] = 0; m_limit[s] = 0; m_tick[s] = 0;
      e.seg = enc(0);
    end else begin
      e.seg = enc(old_disp);
      if (c) begin
        m_cnt[s] = 0; m_presc[s] = 0; m_held[s] = 0; m_limit[s] = 0; m_tick[s] = 0;
      end else if (p) begin
        m_presc[s] = 0; m_tick[s] = 0;
      end else begin
        m_tick[s] = (m_presc[s] == TD - 1);
        if (m_tick[s]) begin
          m_presc[s] = 0;
          if (!d) begin
            if (old_cnt == MAXV) begin
              m_limit[s] = 1;
              m_cnt[s] = (s == 0) ? MAXV : 0;
            end else m_cnt[s] = old_cnt + 1;
          end else begin
            if (old_cnt == 0) begin
              m_limit[s] = 1;
              m_cnt[s] = (s == 0) ? 0 : MAXV;
            end else m_cnt[s] = old_cnt - 1;
          end
        end else m_presc[s] = m_presc[s] + 1;
        if (l) begin
          if (!m_held[s]) m_latch[s] = old_cnt;
          m_held[s] = !m_held[s];
        end
      end
    end
    e.cnt   = 8'(m_cnt[s]);
    e.tick  = m_tick[s];
    e.limit = m_limit[s];
    e.held  = m_held[s];
    e.phase = ph;
    q[s].push_back(e);
  endtask

  task automatic cyc(input logic r, input logic c, input logic p, input logic d,
                     input logic l, input int ph);
    @(negedge clock);
    reset = r; clear = c; pause = p; dir = d; lap = l;
    model_step(0, r, c, p, d, l, ph);
    model_step(1, r, c, p, d, l, ph);
  endtask

  task automatic cmp(input string nm, input int inst, input int ph,
                     input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s inst=%0d phase=%0d t=%0t actual=%h required=%h",
               nm, inst, ph, $time, act, req);
    end
  endtask

  task automatic check_inst(input int s, input logic [7:0] cv, input logic [13:0] sv,
                            input logic tv, input logic lv, input logic hv);
    exp_t e;
    e = q[s].pop_front();
    cmp("count", s, e.phase, 32'(cv), 32'(e.cnt));
    cmp("seg",   s, e.phase, 32'(sv), 32'(e.seg));
    cmp("tick",  s, e.phase, 32'(tv), 32'(e.tick));
    cmp("limit", s, e.phase, 32'(lv), 32'(e.limit));
    cmp("held",  s, e.phase, 32'(hv), 32'(e.held));
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (q[0].size() > 0) check_inst(0, c0, s0, t0, l0, h0);
      if (q[1].size() > 0) check_inst(1, c1, s1, t1, l1, h1);
    end
  end

  initial begin
    logic d;
    // phase 1: reset
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    // phase 2: count up through the 0F -> 10 carry
    for (int i = 0; i < 72; i++) cyc(1, 0, 0, 0, 0, 2);
    // phase 3: pause mid-period at prescaler 2
    for (int i = 0; i < 8 && m_presc[0] != 2; i++) cyc(1, 0, 0, 0, 0, 3);
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0, 0, 3);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 3);
    // phase 4: run up into the all-F limit
    for (int i = 0; i < 1000; i++) cyc(1, 0, 0, 0, 0, 4);
    // phase 5: clear, then count down from 00
    cyc(1, 1, 0, 0, 0, 5);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 1, 0, 5);
    // phase 6: lap coinciding with the tick at count 05, then release
    cyc(1, 1, 0, 0, 0, 6);
    for (int i = 0; i < 40 && !(m_cnt[0] == 5 && m_presc[0] == TD - 1); i++) cyc(1, 0, 0, 0, 0, 6);
    cyc(1, 0, 0, 0, 1, 6);
    for (int i = 0; i < 18; i++) cyc(1, 0, 0, 0, 0, 6);
    cyc(1, 0, 0, 0, 1, 6);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 6);
    // phase 7: reset while held and limit are set; clear+lap together
    cyc(1, 1, 0, 0, 0, 7);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, 0, 7);
    cyc(1, 0, 0, 1, 1, 7);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, 7);
    cyc(0, 0, 0, 1, 0, 7);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 7);
    cyc(1, 0, 0, 0, 1, 7);
    cyc(1, 1, 0, 0, 1, 7);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 7);
    // phase 8: randomized traffic
    d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic r, c, p, l;
      if ($urandom_range(99) == 0) d = ~d;
      r = ($urandom_range(299) != 0);
      c = ($urandom_range(59) == 0);
      p = ($urandom_range(7) == 0);
      l = !p && ($urandom_range(19) == 0);
      cyc(r, c, p, d, l, 8);
    end
    @(posedge clock);
    #3;
    cmp("drained0", 0, 9, 32'(q[0].size()), 32'd0);
    cmp("drained1", 1, 9, 32'(q[1].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_stopwatch_multi.md
# hex_stopwatch_multi

Parametrised hexadecimal stopwatch core for the seven-segment board designs. It has a configurable digit count and tick divider, runs up or down, and offers selectable saturate or wrap at the limits. A lap-hold display latch and a sticky limit flag round it out. It drives N active-low seven-segment digits directly and also exports the raw count for other logic.

## Interface
- DIGITS, 4: number of hex digits (1..8); count width is 4*DIGITS.
- TICK_DIV, 50000000: clock cycles per count step (>= 2).
- SATURATE, 1: 1 = hold at the limit; 0 = wrap around.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- pause  in  1  level; 1 freezes counting.
- clear  in  1  level; synchronous soft clear of count, prescaler and limit flag.
- dir  in  1  0 = count up, 1 = count down; sampled at each tick.
- lap  in  1  single-cycle pulse; toggles the lap-hold display.
- count  out  4*DIGITS  live count register.
- seg  out  7*DIGITS  active-low segments; digit k occupies bits [7k+6:7k], bit order {g,f,e,d,c,b,a}; digit 0 is least significant.
- tick  out  1  one-cycle pulse on each count step.
- limit  out  1  sticky; set when the count hits a limit.
- held  out  1  1 while the display is frozen by lap.

## Operation
- Prescaler counts 0..TICK_DIV-1 while running, i.e. when reset=1, clear=0 and pause=0.
- The internal tick event is prescaler==TICK_DIV-1 while running. On that event the prescaler returns to 0.
- Pause forces the prescaler to 0, so each resume gives a full TICK_DIV period before the next step. Count, display and flags hold during pause.
- Count step, up: count+1 modulo 16^DIGITS with true carry propagation across all digits.
- Count step, down: count-1 modulo 16^DIGITS with true borrow propagation.
- Up at all-F: SATURATE=1 holds all-F; SATURATE=0 goes to 0. limit is set either way.
- Down at 0: SATURATE=1 holds 0; SATURATE=0 goes to all-F. limit is set either way.
- limit clears only on reset or clear.
- Lap: a pulse with held=0 captures count into the display latch and sets held. A pulse with held=1 clears held.
- held is unaffected by pause. clear also clears held.
- Display source is the latch when held=1, otherwise the live count. Each nibble is decoded as below (hex, gfedcba active-low):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E

## Timing
- Reset values: count=0, prescaler=0, latch=0, tick=0, limit=0, held=0, seg = 0x40 in every digit.
- Reset overrides every other input.
- Priority after reset: clear, then pause, then tick/lap.
- count updates on the clock edge that ends the tick cycle. tick is registered and asserts in the same cycle count shows the new value.
- seg is registered: it reflects the new count or latch one cycle after count/held changes.
- Lap and tick in the same cycle: the latch captures the pre-step count; the live count still steps.
- clear and lap in the same cycle: clear wins, and held=0.
- A dir change between ticks takes effect at the next tick only.
- A step that saturates still pulses tick.

## Structure
- Shared package stopwatch_pkg holds:
  - the 16-entry segment constant set (SEG_0..SEG_F, 7 bits, active-low);
  - function hex_to_seg(nibble) returning the 7-bit code.
- One sub-module, hex_seg_decoder: registered 4-bit to 7-bit decode, instantiated DIGITS times via generate.
- Prescaler, count/carry logic, lap latch and flags stay in the top module.

## Test plan
- DIGITS=2, TICK_DIV=4, up, released from reset -> tick every 4 cycles; count 00,01..0F,10 with a correct carry; seg digit0 = 0x40 after reset and digit1 = 0x79 at count 10.
- SATURATE=1, up, preload to FF via ticks -> next tick leaves count=FF, limit=1, tick still pulses; clear -> count=00, limit=0.
- SATURATE=0, dir=1 from 00 -> next tick gives count=FF and limit=1; further ticks give FE, FD.
- pause asserted mid-period (prescaler=2) for 10 cycles, then released -> count unchanged and the next tick arrives exactly 4 cycles after release.
- lap pulse at count 05 coinciding with a tick -> count=06, held=1, seg shows 05 while count reaches 09; a second lap -> seg follows the live count one cycle later.
- reset=0 asserted mid-count with held=1 and limit=1 -> the next edge gives all outputs at their reset values, and seg returns to 0x40 in every digit.
